// File: rtl/hash_sched_if.sv
// Job/result bus between the nonce scheduler and the hash pipeline.
// The scheduler is the master: it issues jobs and receives hashes
// a fixed number of cycles later.
interface hash_sched_if;
  logic              HVld_O;
  logic [15:0][31:0] HMsg_O;
  logic [7:0][31:0]  HH_O;
  logic [31:0]       HBL_O;
  logic              HCs_O;
  logic              HCe_O;
  logic              HRoot_O;
  logic [7:0][31:0]  HHash_I;

  modport master (
    output HVld_O, HMsg_O, HH_O, HBL_O, HCs_O, HCe_O, HRoot_O,
    input  HHash_I
  );

  modport slave (
    input  HVld_O, HMsg_O, HH_O, HBL_O, HCs_O, HCe_O, HRoot_O,
    output HHash_I
  );
endinterface

// File: rtl/hash_sched.sv
// Nonce sweep scheduler. Issues one hash job per cycle with an
// incrementing nonce, tracks each job through a fixed-latency pipeline
// with a tag shift register, and captures the first hash whose word 0
// is at or below the target.
module hash_sched #(
  parameter int HASH_LAT  = 90,
  parameter int NONCE_IDX = 0
) (
  input  logic              Clk,
  input  logic              Rst_I,
  input  logic              Start_I,
  input  logic              Stop_I,
  input  logic [15:0][31:0] Header_I,
  input  logic [7:0][31:0]  ChainVal_I,
  input  logic [31:0]       NonceBase_I,
  input  logic [31:0]       NonceCnt_I,
  input  logic [31:0]       Target_I,
  hash_sched_if.master      hbus,
  output logic              Busy_O,
  output logic              Done_O,
  output logic              Found_O,
  output logic [31:0]       FoundNonce_O,
  output logic [7:0][31:0]  FoundHash_O
);

  localparam int               CNT_W   = $clog2(HASH_LAT + 1);
  localparam logic [3:0]       NIDX    = 4'(NONCE_IDX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0][31:0] header_q, header_d;
  logic [7:0][31:0]  chain_q, chain_d;
  logic [31:0]       nonce_q, nonce_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       target_q, target_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [HASH_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [31:0]       tag_nonce_q [HASH_LAT];
  logic [31:0]       tag_nonce_d [HASH_LAT];
  logic              found_q, found_d;
  logic [31:0]       found_nonce_q, found_nonce_d;
  logic [7:0][31:0]  found_hash_q, found_hash_d;
  logic              done_q, done_d;

  logic              issue;
  logic              exit_vld;
  logic              hit_new;
  logic [15:0][31:0] job_msg;

  // A job goes out only in ISSUE; a stop request or an already captured
  // hit suppresses it in the same cycle.
  assign issue    = (state_q == ST_ISSUE) && !Stop_I && !found_q;
  assign exit_vld = tag_vld_q[HASH_LAT-1];
  assign hit_new  = exit_vld && (hbus.HHash_I[0] <= target_q) && !found_q;

  // Job message: latched header with the nonce word substituted.
  always_comb begin
    job_msg       = header_q;
    job_msg[NIDX] = nonce_q;
  end

  // In-flight job count: +1 per issue, -1 per valid tag leaving the pipe.
  always_comb begin
    inflight_d = inflight_q;
    case ({issue, exit_vld})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  // Tag shift register mirrors the pipeline: slot 0 takes this cycle's
  // job, the last slot lines up with the hash now on HHash_I.
  always_comb begin
    tag_vld_d[0]   = issue;
    tag_nonce_d[0] = nonce_q;
    for (int i = 1; i < HASH_LAT; i++) begin
      tag_vld_d[i]   = tag_vld_q[i-1];
      tag_nonce_d[i] = tag_nonce_q[i-1];
    end
  end

  // Sequencer: job acceptance, nonce sweep, drain, hit capture.
  always_comb begin
    // NOTE: every signal gets its default before any branch, so no path can leave a latch.
    state_d       = state_q;
    header_d      = header_q;
    chain_d       = chain_q;
    nonce_d       = nonce_q;
    rem_d         = rem_q;
    target_d      = target_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;

    // First qualifying hash of the job wins; later ones are dropped.
    if (hit_new) begin
      found_d       = 1'b1;
      found_nonce_d = tag_nonce_q[HASH_LAT-1];
      found_hash_d  = hbus.HHash_I;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start_I) begin
          header_d = Header_I;
          chain_d  = ChainVal_I;
          nonce_d  = NonceBase_I;
          rem_d    = NonceCnt_I;
          target_d = Target_I;
          found_d  = 1'b0;
          state_d  = (NonceCnt_I != '0) ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          nonce_d = nonce_q + 32'd1;
          rem_d   = rem_q - 32'd1;
          if (rem_q == 32'd1) state_d = ST_DRAIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (inflight_d == '0) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // Control state with synchronous reset; dropping every tag valid bit
  // makes pre-reset jobs invisible when their hashes emerge.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (Rst_I) begin
      state_q       <= ST_IDLE;
      inflight_q    <= '0;
      tag_vld_q     <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      tag_vld_q     <= tag_vld_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      done_q        <= done_d;
    end
  end

  // Datapath registers; contents only matter behind a valid state or tag.
  always_ff @(posedge Clk) begin
    // NOTE: no reset on job data and tag nonces -- they are qualified by state and valid bits.
    header_q <= header_d;
    chain_q  <= chain_d;
    nonce_q  <= nonce_d;
    rem_q    <= rem_d;
    target_q <= target_d;
    for (int i = 0; i < HASH_LAT; i++) tag_nonce_q[i] <= tag_nonce_d[i];
  end

  assign hbus.HVld_O  = issue;
  assign hbus.HMsg_O  = job_msg;
  assign hbus.HH_O    = chain_q;
  assign hbus.HBL_O   = 32'd64;
  assign hbus.HCs_O   = 1'b1;
  assign hbus.HCe_O   = 1'b1;
  assign hbus.HRoot_O = 1'b1;

  assign Busy_O       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign Done_O       = done_q;
  assign Found_O      = found_q;
  assign FoundNonce_O = found_nonce_q;
  assign FoundHash_O  = found_hash_q;

endmodule

// File: tb/tb_hash_sched.sv
// Self-checking bench for hash_sched: a fixed-latency pipeline model
// returns a per-nonce hash, issued jobs are checked against a queue of
// expected nonces, and each scenario checks its own completion results.
module tb_hash_sched;

  localparam int L    = 90;
  localparam int NIDX = 0;

  logic              Clk = 1'b0;
  logic              Rst_I = 1'b1;
  logic              Start_I = 1'b0;
  logic              Stop_I = 1'b0;
  logic [15:0][31:0] Header_I = '0;
  logic [7:0][31:0]  ChainVal_I = '0;
  logic [31:0]       NonceBase_I = '0;
  logic [31:0]       NonceCnt_I = '0;
  logic [31:0]       Target_I = '0;
  logic              Busy_O, Done_O, Found_O;
  logic [31:0]       FoundNonce_O;
  logic [7:0][31:0]  FoundHash_O;

  hash_sched_if hbus();

  hash_sched #(.HASH_LAT(L), .NONCE_IDX(NIDX)) dut (
    .Clk(Clk), .Rst_I(Rst_I), .Start_I(Start_I), .Stop_I(Stop_I),
    .Header_I(Header_I), .ChainVal_I(ChainVal_I), .NonceBase_I(NonceBase_I),
    .NonceCnt_I(NonceCnt_I), .Target_I(Target_I), .hbus(hbus),
    .Busy_O(Busy_O), .Done_O(Done_O), .Found_O(Found_O),
    .FoundNonce_O(FoundNonce_O), .FoundHash_O(FoundHash_O)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Bench state
  int                n_assert = 0;
  int                n_fail = 0;
  logic [31:0]       exp_q [$];
  logic [15:0][31:0] hdr_exp;
  logic [7:0][31:0]  chain_exp;
  int                start_cyc, first_vld_cyc, issue_cnt, done_cnt = 0, done_cyc;

  // Pipeline hash model configuration
  bit          hit_all = 1'b0, ha_en = 1'b0, hb_en = 1'b0;
  logic [31:0] ha = '0, hb = '0, ha_val = '0, hb_val = '0, miss_val = 32'hFFFF_FFFF;

  function automatic logic [7:0][31:0] hash_of(input logic [31:0] n);
    logic [7:0][31:0] h;
    for (int i = 0; i < 8; i++) h[i] = n ^ 32'(32'h9E37_79B9 * (i + 1));
    if (hit_all)                h[0] = 32'h0;
    else if (ha_en && n == ha)  h[0] = ha_val;
    else if (hb_en && n == hb)  h[0] = hb_val;
    else                        h[0] = miss_val;
    return h;
  endfunction

  // Fixed-latency pipeline model; invalid slots present an all-zero hash
  // (which would be a hit) so ignoring invalid tags is exercised.
  logic [L-1:0] mv = '0;
  logic [31:0]  mn [L];
  always @(posedge Clk) begin
    mv    <= {mv[L-2:0], hbus.HVld_O};
    mn[0] <= hbus.HMsg_O[NIDX];
    for (int i = 1; i < L; i++) mn[i] <= mn[i-1];
  end
  assign hbus.HHash_I = mv[L-1] ? hash_of(mn[L-1]) : '0;

  // Scoreboard: every issued job must match the next expected nonce.
  task automatic monitor();
    logic [31:0]       en;
    logic [15:0][31:0] em;
    forever begin
      @(negedge Clk);
      if (Rst_I !== 1'b1) begin
        if (hbus.HVld_O === 1'b1) begin
          issue_cnt++;
          if (first_vld_cyc < 0) first_vld_cyc = cyc;
          n_assert++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: HVld_O with nonce %h at cycle %0d, no job expected",
                     hbus.HMsg_O[NIDX], cyc);
          end else begin
            en       = exp_q.pop_front();
            em       = hdr_exp;
            em[NIDX] = en;
            if (hbus.HMsg_O !== em || hbus.HH_O !== chain_exp) begin
              n_fail++;
              $display("FAIL issue_job: got nonce %h (msg ok %0b, chain ok %0b), expected nonce %h",
                       hbus.HMsg_O[NIDX], hbus.HMsg_O === em, hbus.HH_O === chain_exp, en);
            end
          end
          n_assert++;
          if ({hbus.HBL_O, hbus.HCs_O, hbus.HCe_O, hbus.HRoot_O} !== {32'd64, 3'b111}) begin
            n_fail++;
            $display("FAIL job_const: HBL=%0d flags=%b, expected 64 / 111", hbus.HBL_O,
                     {hbus.HCs_O, hbus.HCe_O, hbus.HRoot_O});
          end
        end
        if (Done_O === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] cnt,
                           input logic [31:0] tgt, input bit accepted);
    @(posedge Clk); #1;
    for (int i = 0; i < 16; i++) Header_I[i] = $urandom;
    for (int i = 0; i < 8; i++)  ChainVal_I[i] = $urandom;
    NonceBase_I = base;
    NonceCnt_I  = cnt;
    Target_I    = tgt;
    if (accepted) begin
      hdr_exp       = Header_I;
      chain_exp     = ChainVal_I;
      start_cyc     = cyc;
      issue_cnt     = 0;
      first_vld_cyc = -1;
    end
    Start_I = 1'b1;
    @(posedge Clk); #1;
    Start_I = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int d0;
    d0        = done_cnt;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge Clk); #1;
      if (done_cnt != d0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic set_hits(input bit all, input bit a_en, input logic [31:0] a, input logic [31:0] a_v,
                          input bit b_en, input logic [31:0] b, input logic [31:0] b_v);
    hit_all = all; ha_en = a_en; ha = a; ha_val = a_v; hb_en = b_en; hb = b; hb_val = b_v;
  endtask

  task automatic test_reset();
    Rst_I = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Rst_I = 1'b0;
    n_assert++; if (hbus.HVld_O !== 1'b0) begin n_fail++; $display("FAIL reset_hvld: got %b want 0", hbus.HVld_O); end
    n_assert++; if (Busy_O !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy_O); end
    n_assert++; if (Done_O !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done_O); end
    n_assert++; if (Found_O !== 1'b0) begin n_fail++; $display("FAIL reset_found: got %b want 0", Found_O); end
    n_assert++; if (FoundNonce_O !== 32'h0) begin n_fail++; $display("FAIL reset_fnonce: got %h want 0", FoundNonce_O); end
    n_assert++; if (FoundHash_O !== '0) begin n_fail++; $display("FAIL reset_fhash: got %h want 0", FoundHash_O); end
  endtask

  task automatic test_sweep();
    bit to;
    set_hits(1'b0, 1'b1, 32'h12, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h10 + 32'(i));
    start_job(32'h10, 32'd5, 32'h0, 1'b1);
    wait_done(2000, to);
    n_assert++; if (to) begin n_fail++; $display("FAIL sweep_timeout: no Done_O, want one"); end
    n_assert++; if (first_vld_cyc != start_cyc + 1) begin n_fail++; $display("FAIL sweep_first_vld: cycle %0d want %0d", first_vld_cyc, start_cyc + 1); end
    n_assert++; if (done_cyc != start_cyc + 6 + L) begin n_fail++; $display("FAIL sweep_done_cycle: got %0d want %0d", done_cyc, start_cyc + 6 + L); end
    n_assert++; if (issue_cnt != 5 || exp_q.size() != 0) begin n_fail++; $display("FAIL sweep_issue_count: got %0d want 5", issue_cnt); end
    n_assert++; if (Found_O !== 1'b1) begin n_fail++; $display("FAIL sweep_found: got %b want 1", Found_O); end
    n_assert++; if (FoundNonce_O !== 32'h12) begin n_fail++; $display("FAIL sweep_fnonce: got %h want 00000012", FoundNonce_O); end
    n_assert++; if (FoundHash_O !== hash_of(32'h12)) begin n_fail++; $display("FAIL sweep_fhash: got %h want %h", FoundHash_O, hash_of(32'h12)); end
    n_assert++; if (Done_O !== 1'b0 || Busy_O !== 1'b0) begin n_fail++; $display("FAIL sweep_after_done: Done=%b Busy=%b want 0/0", Done_O, Busy_O); end
  endtask

  task automatic test_zero_count();
    bit to;
    start_job(32'h77, 32'd0, 32'h0, 1'b1);
    wait_done(50, to);
    n_assert++; if (to) begin n_fail++; $display("FAIL zero_timeout: no Done_O, want one"); end
    n_assert++; if (done_cyc != start_cyc + 2) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, start_cyc + 2); end
    n_assert++; if (issue_cnt != 0) begin n_fail++; $display("FAIL zero_issue_count: got %0d want 0", issue_cnt); end
    n_assert++; if (Found_O !== 1'b0) begin n_fail++; $display("FAIL zero_found_cleared: got %b want 0", Found_O); end
  endtask

  task automatic test_wrap();
    bit to;
    int d0;
    set_hits(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0);         exp_q.push_back(32'h1);
    d0 = done_cnt;
    start_job(32'hFFFF_FFFE, 32'd4, 32'h0, 1'b1);
    wait_done(2000, to);
    repeat (5) @(posedge Clk);
    #1;
    n_assert++; if (to) begin n_fail++; $display("FAIL wrap_timeout: no Done_O, want one"); end
    n_assert++; if (issue_cnt != 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_issue_count: got %0d want 4", issue_cnt); end
    n_assert++; if (Found_O !== 1'b0) begin n_fail++; $display("FAIL wrap_found: got %b want 0", Found_O); end
    n_assert++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_target_boundary();
    bit to;
    set_hits(1'b0, 1'b1, 32'h50, 32'h101, 1'b1, 32'h51, 32'h100);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h50 + 32'(i));
    start_job(32'h50, 32'd3, 32'h100, 1'b1);
    wait_done(2000, to);
    n_assert++; if (to) begin n_fail++; $display("FAIL bound_timeout: no Done_O, want one"); end
    n_assert++; if (Found_O !== 1'b1 || FoundNonce_O !== 32'h51) begin n_fail++; $display("FAIL bound_fnonce: found=%b nonce=%h want 1/00000051", Found_O, FoundNonce_O); end
    n_assert++; if (FoundHash_O !== hash_of(32'h51)) begin n_fail++; $display("FAIL bound_fhash: got %h want %h", FoundHash_O, hash_of(32'h51)); end
  endtask

  task automatic test_early_hit();
    bit to;
    logic [31:0] base;
    base = 32'h1000;
    set_hits(1'b0, 1'b1, base + 32'd3, 32'h0, 1'b1, base + 32'd7, 32'h0);
    // Hit at base+3 leaves the pipe L cycles after issue; one more cycle
    // to register it, so L+4 jobs go out in total.
    for (int i = 0; i < L + 4; i++) exp_q.push_back(base + 32'(i));
    start_job(base, 32'd200, 32'h0, 1'b1);
    wait_done(2000, to);
    n_assert++; if (to) begin n_fail++; $display("FAIL early_timeout: no Done_O, want one"); end
    n_assert++; if (issue_cnt != L + 4 || exp_q.size() != 0) begin n_fail++; $display("FAIL early_issue_count: got %0d want %0d", issue_cnt, L + 4); end
    n_assert++; if (FoundNonce_O !== base + 32'd3) begin n_fail++; $display("FAIL early_fnonce: got %h want %h", FoundNonce_O, base + 32'd3); end
    n_assert++; if (FoundHash_O !== hash_of(base + 32'd3)) begin n_fail++; $display("FAIL early_fhash: got %h want %h", FoundHash_O, hash_of(base + 32'd3)); end
    n_assert++; if (done_cyc != start_cyc + 5 + 2 * L) begin n_fail++; $display("FAIL early_done_cycle: got %0d want %0d", done_cyc, start_cyc + 5 + 2 * L); end
    exp_q.delete();
  endtask

  task automatic test_stop();
    bit to;
    int d0, guard;
    set_hits(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h2000 + 32'(i));
    d0 = done_cnt;
    start_job(32'h2000, 32'd500, 32'h0, 1'b1);
    guard = 0;
    while (issue_cnt < 10 && guard < 100) begin
      @(posedge Clk); #1;
      guard++;
    end
    n_assert++; if (issue_cnt != 10) begin n_fail++; $display("FAIL stop_reach_10: got %0d issues want 10", issue_cnt); end
    Stop_I = 1'b1;
    @(posedge Clk); #1;
    Stop_I = 1'b0;
    n_assert++; if (Busy_O !== 1'b1) begin n_fail++; $display("FAIL stop_busy_drain: got %b want 1", Busy_O); end
    start_job(32'h9999, 32'd5, 32'h0, 1'b0);
    wait_done(2000, to);
    repeat (L) @(posedge Clk);
    #1;
    n_assert++; if (to) begin n_fail++; $display("FAIL stop_timeout: no Done_O, want one"); end
    n_assert++; if (done_cyc != start_cyc + 11 + L) begin n_fail++; $display("FAIL stop_done_cycle: got %0d want %0d", done_cyc, start_cyc + 11 + L); end
    n_assert++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stop_done_count: got %0d want 1", done_cnt - d0); end
    n_assert++; if (issue_cnt != 10 || exp_q.size() != 0) begin n_fail++; $display("FAIL stop_issue_count: got %0d want 10", issue_cnt); end
  endtask

  task automatic test_reset_mid();
    int d0, bad;
    set_hits(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 1000; i++) exp_q.push_back(32'h5000 + 32'(i));
    start_job(32'h5000, 32'd1000, 32'h0, 1'b1);
    repeat (19) @(posedge Clk);
    #1 Rst_I = 1'b1;
    @(posedge Clk);
    #1 Rst_I = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    n_assert++; if (hbus.HVld_O !== 1'b0 || Busy_O !== 1'b0) begin n_fail++; $display("FAIL rmid_hvld_busy: got %b/%b want 0/0", hbus.HVld_O, Busy_O); end
    n_assert++; if (Done_O !== 1'b0 || Found_O !== 1'b0) begin n_fail++; $display("FAIL rmid_done_found: got %b/%b want 0/0", Done_O, Found_O); end
    n_assert++; if (FoundNonce_O !== 32'h0 || FoundHash_O !== '0) begin n_fail++; $display("FAIL rmid_result: nonce %h want 0, hash zero %0b", FoundNonce_O, FoundHash_O === '0); end
    bad = 0;
    for (int k = 0; k < 2 * L; k++) begin
      @(posedge Clk); #1;
      if (Found_O !== 1'b0 || Done_O !== 1'b0) bad++;
    end
    n_assert++; if (bad != 0) begin n_fail++; $display("FAIL rmid_quiet: %0d cycles with Found/Done set, want 0", bad); end
    n_assert++; if (done_cnt != d0) begin n_fail++; $display("FAIL rmid_done_count: got %0d want 0", done_cnt - d0); end
  endtask

  initial begin
    issue_cnt     = 0;
    first_vld_cyc = -1;
    fork
      monitor();
    join_none
    test_reset();
    test_sweep();
    test_zero_count();
    test_wrap();
    test_target_boundary();
    test_early_hit();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_sched.md
HASH_SCHED -- requirements
Module: hash_sched

Interface
REQ-001 Parameter HASH_LAT, default 90: fixed latency in cycles from an issued job to its hash on HHash_I.
REQ-002 Parameter NONCE_IDX, default 0: message word index that carries the nonce.
REQ-003 Clk  in  1  the only clock; all logic is rising-edge triggered.
REQ-004 Rst_I  in  1  synchronous, active-high reset.
REQ-005 Start_I  in  1  single-cycle job start; accepted only in IDLE or DONE.
REQ-006 Stop_I  in  1  abort request; stops issue, then drains.
REQ-007 Header_I  in  16x32  message template.
REQ-008 ChainVal_I  in  8x32  input chaining value.
REQ-009 NonceBase_I  in  32  first nonce.
REQ-010 NonceCnt_I  in  32  number of nonces to sweep.
REQ-011 Target_I  in  32  hit threshold.
REQ-012 HVld_O  out  1  job-valid strobe to the hash pipeline, one job per cycle.
REQ-013 HMsg_O  out  16x32  job message.
REQ-014 HH_O  out  8x32  job chaining value.
REQ-015 HBL_O  out  32  block length, constant 64.
REQ-016 HCs_O, HCe_O, HRoot_O  out  1 each  chunk-start, chunk-end and root flags, constant 1.
REQ-017 HHash_I  in  8x32  hash result from the pipeline.
REQ-018 Busy_O  out  1  high in ISSUE and DRAIN.
REQ-019 Done_O  out  1  one-cycle pulse when a job completes.
REQ-020 Found_O  out  1  a hit was captured; held until the next accepted Start_I or reset.
REQ-021 FoundNonce_O  out  32, FoundHash_O  out  8x32  captured hit.

Function
REQ-022 FSM states: IDLE, ISSUE, DRAIN, DONE.
REQ-023 On an accepted Start_I, latch Header_I, ChainVal_I, NonceBase_I, NonceCnt_I and Target_I, and clear Found_O.
  - NonceCnt_I != 0: go to ISSUE.
  - NonceCnt_I == 0: go to DRAIN.
REQ-024 Start_I in ISSUE or DRAIN is ignored.
REQ-025 In ISSUE, each cycle:
  - HVld_O=1.
  - HMsg_O = latched header with word NONCE_IDX replaced by the current nonce.
  - HH_O = latched chaining value.
  - Nonce increments modulo 2^32 (0xFFFFFFFF wraps to 0).
  - Remaining count decrements.
REQ-026 First HVld_O occurs the cycle after Start_I, carrying NonceBase_I; exactly NonceCnt_I jobs are issued unless interrupted.
REQ-027 ISSUE goes to DRAIN after the last job is issued, or on Stop_I, or on a captured hit. Stop_I blocks issue in the same cycle.
REQ-028 HVld_O=0 in every state except ISSUE.
REQ-029 Tag tracking: a HASH_LAT-deep shift register carries {valid, nonce} for every cycle.
  - An entry issued at cycle c is evaluated against HHash_I at cycle c+HASH_LAT.
  - HHash_I is ignored when the emerging tag is invalid.
REQ-030 Hit test: HHash_I[0] <= latched target, unsigned 32-bit compare.
REQ-031 The first hit of a job sets Found_O and loads FoundNonce_O and FoundHash_O. Later hits of the same job are discarded and the captured values do not change.
REQ-032 DRAIN stays until the in-flight counter (0..HASH_LAT) reaches 0, then goes to DONE.
  - The counter increments per issue and decrements per valid tag exit.
  - Simultaneous increment and decrement leave it unchanged.
REQ-033 Done_O pulses for exactly one cycle, on entry to DONE.
REQ-034 DONE stays until Start_I, which is handled as in IDLE; Found_O and the result stay valid in DONE.
REQ-035 Hits evaluated during DRAIN, including after Stop_I, are captured if they are the first.

Reset
REQ-036 Rst_I forces IDLE and clears every tag valid bit and the in-flight counter.
REQ-037 Reset values: HVld_O=0, Busy_O=0, Done_O=0, Found_O=0, FoundNonce_O=0, FoundHash_O=0.
REQ-038 Reset applied mid-job discards all in-flight tags: no Done_O pulse and no hit capture from pre-reset jobs.

Verification
REQ-039 Sweep: base 0x10, count 5, target 0; pipeline model returns hash[0] = 0 only for nonce 0x12.
  - Required: HVld_O for 5 cycles carrying 0x10..0x14.
  - Required: Found_O=1, FoundNonce_O=0x12.
  - Required: Done_O at Start_I cycle + 5 + HASH_LAT + 1.
REQ-040 Wrap: base 0xFFFFFFFE, count 4.
  - Required: issued nonces 0xFFFFFFFE, 0xFFFFFFFF, 0, 1.
  - Required: no hit with target 0 and nonzero hashes; Found_O=0, one Done_O.
REQ-041 Zero count: NonceCnt_I=0 -> no HVld_O; Done_O 2 cycles after Start_I; Found_O=0.
REQ-042 Early hit: count 200, first hit at nonce base+3.
  - Required: issue stops after the hit is captured.
  - Required: a later in-flight hit at base+7 does not change FoundNonce_O (stays base+3).
REQ-043 Stop: Stop_I asserted after 10 issues.
  - Required: no further HVld_O.
  - Required: Done_O exactly once after the 10 tags drain; Start_I during DRAIN is ignored.
REQ-044 Reset mid-job: Rst_I 20 cycles into a 1000-nonce job -> all outputs at reset values and no Done_O or Found_O within the following 2*HASH_LAT cycles.
